// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306/SH1106 frame writer: FSM encoding and
// the fixed control/command bytes placed on the I2C register interface.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CMD_PAGE   = 3'd1,
        ST_CMD_COL_LO = 3'd2,
        ST_CMD_COL_HI = 3'd3,
        ST_FETCH      = 3'd4,
        ST_DATA       = 3'd5,
        ST_FINISH     = 3'd6
    } state_t;

    // Control byte that prefixes each I2C transfer
    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    // Addressing command bases; low bits carry page or column nibble
    localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;
    localparam logic [7:0] CMD_COL_LO_BASE = 8'h00;
    localparam logic [7:0] CMD_COL_HI_BASE = 8'h10;

    function automatic logic is_write_state(input state_t s);
        logic w;
        case (s)
            ST_CMD_PAGE, ST_CMD_COL_LO, ST_CMD_COL_HI, ST_DATA: w = 1'b1;
            default:                                            w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/oled_frame_writer.sv
// Streams one full frame to an SSD1306-style OLED over an external I2C byte
// master: per page, three addressing commands followed by COLS data bytes.
module oled_frame_writer
    import oled_pkg::*;
#(
    parameter int COLS       = 128,
    parameter int PAGES      = 8,
    parameter int COL_OFFSET = 0,
    localparam int FB_AW     = $clog2(COLS * PAGES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fill_en,
    input  logic [7:0]       fill_pattern,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [7:0]       fb_data,
    input  logic             i2c_done,
    output logic             write_i2c_en,
    output logic [7:0]       reg_addr,
    output logic [7:0]       reg_data,
    output logic             busy,
    output logic             done
);

    localparam int         CW        = $clog2(COLS);
    localparam logic [7:0] COL_OFF8  = 8'(COL_OFFSET);
    localparam logic [7:0] COL_LO_CMD = CMD_COL_LO_BASE | {4'h0, COL_OFF8[3:0]};
    localparam logic [7:0] COL_HI_CMD = CMD_COL_HI_BASE | {4'h0, COL_OFF8[7:4]};
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [2:0]    PAGE_LAST = 3'(PAGES - 1);

    state_t        state, state_n;
    logic [CW-1:0] col, col_n;
    logic [2:0]    page, page_n;
    logic          issue;
    logic          fill_en_q;
    logic [7:0]    pattern_q;
    logic [7:0]    fb_q;
    logic          accept;
    logic          col_last, page_last;

    // issue marks the request cycle of a write state; a done seen then is stale
    assign accept    = is_write_state(state) && !issue && i2c_done;
    assign col_last  = (col == COL_LAST);
    assign page_last = (page == PAGE_LAST);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:       if (start)  state_n = ST_CMD_PAGE;
            ST_CMD_PAGE:   if (accept) state_n = ST_CMD_COL_LO;
            ST_CMD_COL_LO: if (accept) state_n = ST_CMD_COL_HI;
            ST_CMD_COL_HI: if (accept) state_n = ST_FETCH;
            ST_FETCH:                  state_n = ST_DATA;
            ST_DATA: begin
                if (accept) begin
                    if (!col_last)       state_n = ST_FETCH;
                    else if (!page_last) state_n = ST_CMD_PAGE;
                    else                 state_n = ST_FINISH;
                end
            end
            ST_FINISH:                 state_n = ST_IDLE;
            default:                   state_n = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- position counters
    always_comb begin
        col_n  = col;
        page_n = page;
        if (reset || (state == ST_IDLE && start)) begin
            col_n  = '0;
            page_n = '0;
        end else if (state == ST_DATA && accept) begin
            if (!col_last) begin
                col_n = col + 1'b1;
            end else if (!page_last) begin
                col_n  = '0;
                page_n = page + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            page      <= '0;
            issue     <= 1'b0;
            fill_en_q <= 1'b0;
            pattern_q <= 8'h00;
            fb_q      <= 8'h00;
        end else begin
            col   <= col_n;
            page  <= page_n;
            issue <= is_write_state(state_n) && (state_n != state);
            if (state == ST_IDLE && start) begin
                fill_en_q <= fill_en;
                pattern_q <= fill_pattern;
            end
            if (state == ST_FETCH) fb_q <= fb_data;
        end
    end

    // ---------------------------------------------------------------- outputs
    // The address is presented from the next position so the one-cycle-late
    // framebuffer byte is already valid for capture at the end of FETCH.
    always_comb begin
        write_i2c_en = issue;
        busy         = (state != ST_IDLE);
        done         = (state == ST_FINISH);
        reg_addr     = CTRL_CMD;
        reg_data     = 8'h00;
        fb_addr      = FB_AW'(int'(page_n) * COLS + int'(col_n));
        case (state)
            ST_CMD_PAGE:   reg_data = CMD_PAGE_BASE | {5'd0, page};
            ST_CMD_COL_LO: reg_data = COL_LO_CMD;
            ST_CMD_COL_HI: reg_data = COL_HI_CMD;
            ST_DATA: begin
                reg_addr = CTRL_DATA;
                reg_data = fill_en_q ? pattern_q : fb_q;
            end
            default: ;
        endcase
    end

endmodule
